// File: rtl/flag_pkg.sv
// flag_pkg: shared types for the MCU status/interrupt-enable flag controller.
//   flags_t      : packed {ie, z, c}, also the shadow stack entry format.
//   fctl_state_t : interrupt-entry sequencer states.
//   FLAGS_RST    : reset value of the flag triple. IE is overridden by the IE_RST
//                  parameter of flag_ctrl.
// Used by flag_stack and flag_ctrl.
package flag_pkg;

  typedef struct packed {
    logic ie;
    logic z;
    logic c;
  } flags_t;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    ENTRY = 2'd1,
    HOLD  = 2'd2
  } fctl_state_t;

  localparam flags_t FLAGS_RST = '{ie: 1'b0, z: 1'b0, c: 1'b0};

endpackage

// File: rtl/flag_stack.sv
// flag_stack: LIFO shadow stack of flags_t entries used to save {IE,Z,C} on interrupt
// entry and restore them on return.
// Parameters:
//   STACK_DEPTH : number of entries (1..16).
// Ports:
//   clk   in   system clock, rising edge
//   rst_n in   asynchronous active-low reset, empties the stack
//   push  in   write din on top; ignored (entry lost) when full
//   pop   in   remove top entry; ignored when empty
//   din   in   entry to push
//   dout  out  current top entry; when empty, the last entry popped (or reset value)
//   depth out  number of entries held
//   full  out  depth == STACK_DEPTH
//   empty out  depth == 0
module flag_stack
  import flag_pkg::*;
#(
  parameter int unsigned STACK_DEPTH = 4,
  localparam int unsigned DW = $clog2(STACK_DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic          pop,
  input  flags_t        din,
  output flags_t        dout,
  output logic [DW-1:0] depth,
  output logic          full,
  output logic          empty
);

  // Address width of the storage array; at least one bit for a single-entry stack.
  localparam int unsigned AW = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

  flags_t        mem_q [STACK_DEPTH];
  logic [DW-1:0] depth_q;
  logic [AW-1:0] wr_idx;
  logic [AW-1:0] rd_idx;

  assign full  = (depth_q == DW'(STACK_DEPTH));
  assign empty = (depth_q == '0);
  assign depth = depth_q;

  // wr_idx is only used when not full, so truncation never aliases a live slot.
  assign wr_idx = AW'(depth_q);
  // Slot 0 holds the last popped entry once the stack drains back to empty.
  assign rd_idx = empty ? '0 : AW'(depth_q - DW'(1));
  assign dout   = mem_q[rd_idx];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      depth_q <= '0;
      for (int unsigned i = 0; i < STACK_DEPTH; i++) begin
        mem_q[i] <= FLAGS_RST;
      end
    end else if (push && !full) begin
      mem_q[wr_idx] <= din;
      depth_q       <= depth_q + DW'(1);
    end else if (pop && !empty) begin
      depth_q <= depth_q - DW'(1);
    end
  end

endmodule

// File: rtl/flag_ctrl.sv
// flag_ctrl: MCU carry/zero flags and interrupt-enable flag with interrupt-entry sequencing.
// Arbitrates per-cycle set/clear/load requests, runs the interrupt-entry handshake and
// saves/restores {IE,Z,C} through a LIFO shadow stack (flag_stack).
// Build option:
//   FLAG_STACK_ERR_EN : when defined, adds the sticky stk_err output (set on an entry
//                       attempt while the stack is full or a return with an empty stack)
//                       and holds off interrupt entry while the stack is full.
// Parameters:
//   STACK_DEPTH : shadow stack entries (1..16)
//   IE_RST      : IE value after reset
// Ports:
//   clk, rst_n            clock (rising edge), asynchronous active-low reset
//   c_in, z_in            ALU carry / zero results
//   c_ld, z_ld            load C / Z from the ALU results
//   c_set, c_clr          force C to 1 / 0
//   ie_set, ie_clr        SEI / CLI
//   irq                   level interrupt request
//   retie                 return from ISR, restores {IE,Z,C} from the stack
//   int_ack               one-cycle pulse while the interrupt is being taken
//   c_out, z_out, ie_out  flag values
//   depth                 shadow stack occupancy
//   stk_full, stk_empty   shadow stack status
//   stk_err               sticky stack error (FLAG_STACK_ERR_EN only)
module flag_ctrl
  import flag_pkg::*;
#(
  parameter int unsigned STACK_DEPTH = 4,
  parameter logic        IE_RST      = 1'b0,
  localparam int unsigned DW = $clog2(STACK_DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          c_in,
  input  logic          z_in,
  input  logic          c_ld,
  input  logic          z_ld,
  input  logic          c_set,
  input  logic          c_clr,
  input  logic          ie_set,
  input  logic          ie_clr,
  input  logic          irq,
  output logic          int_ack,
  input  logic          retie,
  output logic          c_out,
  output logic          z_out,
  output logic          ie_out,
  output logic [DW-1:0] depth,
  output logic          stk_full,
`ifdef FLAG_STACK_ERR_EN
  output logic          stk_err,
`endif
  output logic          stk_empty
);

  localparam flags_t RST_FLAGS = '{ie: IE_RST, z: FLAGS_RST.z, c: FLAGS_RST.c};

  fctl_state_t   state_q, state_d;
  flags_t        flags_q, flags_d;
  flags_t        stk_dout;
  logic [DW-1:0] stk_depth;
  logic          stk_full_w;
  logic          stk_empty_w;
  logic          push;
  logic          pop;
  logic          entry_blocked;
  logic          entry_req;

  flag_stack #(
    .STACK_DEPTH(STACK_DEPTH)
  ) u_stack (
    .clk  (clk),
    .rst_n(rst_n),
    .push (push),
    .pop  (pop),
    .din  (flags_q),
    .dout (stk_dout),
    .depth(stk_depth),
    .full (stk_full_w),
    .empty(stk_empty_w)
  );

`ifdef FLAG_STACK_ERR_EN
  assign entry_blocked = stk_full_w;
`else
  assign entry_blocked = 1'b0;
`endif

  assign entry_req = irq & flags_q.ie & ~entry_blocked;

  // Sequencer: RUN -> ENTRY (push, ack) -> HOLD (in ISR) -> RUN once the stack drains.
  always_comb begin
    state_d = state_q;
    push    = 1'b0;
    pop     = 1'b0;
    unique case (state_q)
      RUN: begin
        // retie outside an ISR is ignored but still suppresses entry this cycle.
        if (entry_req && !retie) begin
          state_d = ENTRY;
        end
      end
      ENTRY: begin
        // Pushes the pre-update flags; the stack discards it when already full.
        push    = 1'b1;
        state_d = HOLD;
      end
      HOLD: begin
        // retie wins over a nested request; irq is looked at again next cycle.
        if (retie) begin
          if (!stk_empty_w) begin
            pop = 1'b1;
            if (stk_depth == DW'(1)) begin
              state_d = RUN;
            end
          end else begin
            state_d = RUN;
          end
        end else if (entry_req) begin
          state_d = ENTRY;
        end
      end
      default: begin
        state_d = RUN;
      end
    endcase
  end

  // Flag next-state with per-flag priorities; a restore overrides every request.
  always_comb begin
    flags_d = flags_q;
    if (pop) begin
      flags_d = stk_dout;
    end else begin
      if (c_clr) begin
        flags_d.c = 1'b0;
      end else if (c_set) begin
        flags_d.c = 1'b1;
      end else if (c_ld) begin
        flags_d.c = c_in;
      end

      if (z_ld) begin
        flags_d.z = z_in;
      end

      if (state_q == ENTRY) begin
        flags_d.ie = 1'b0;
      end else if (ie_clr) begin
        flags_d.ie = 1'b0;
      end else if (ie_set) begin
        flags_d.ie = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RUN;
      flags_q <= RST_FLAGS;
    end else begin
      state_q <= state_d;
      flags_q <= flags_d;
    end
  end

`ifdef FLAG_STACK_ERR_EN
  logic err_evt;
  logic stk_err_q;

  // Overflow is an entry attempt refused because the stack is full; underflow is a
  // return from an ISR with nothing to restore.
  always_comb begin
    err_evt = 1'b0;
    if ((state_q == HOLD) && retie && stk_empty_w) begin
      err_evt = 1'b1;
    end
    if (((state_q == RUN) || (state_q == HOLD)) && !retie && irq && flags_q.ie &&
        stk_full_w) begin
      err_evt = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stk_err_q <= 1'b0;
    end else if (err_evt) begin
      stk_err_q <= 1'b1;
    end
  end

  assign stk_err = stk_err_q;
`endif

  assign int_ack   = (state_q == ENTRY);
  assign c_out     = flags_q.c;
  assign z_out     = flags_q.z;
  assign ie_out    = flags_q.ie;
  assign depth     = stk_depth;
  assign stk_full  = stk_full_w;
  assign stk_empty = stk_empty_w;

  // ENTRY always lasts exactly one cycle.
  assert property (@(posedge clk) disable iff (!rst_n) int_ack |=> !int_ack);

endmodule

// File: tb/tb_flag_ctrl.sv
module tb_flag_ctrl;

  localparam int unsigned DEPTH = 2;
  localparam int unsigned DW    = $clog2(DEPTH + 1);
  localparam bit          IE_RV = 1'b0;
`ifdef FLAG_STACK_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic c_in, z_in, c_ld, z_ld, c_set, c_clr, ie_set, ie_clr, irq, retie;
  logic int_ack, c_out, z_out, ie_out, stk_full, stk_empty;
  logic [DW-1:0] depth;
`ifdef FLAG_STACK_ERR_EN
  logic stk_err;
`endif

  int total = 0;
  int bad = 0;

  // Reference model: flag bits, ISR bookkeeping and a queue as the shadow stack.
  bit       m_c, m_z, m_ie;
  bit       m_ack;   // interrupt being taken this cycle
  bit       m_isr;   // inside an ISR
  bit       m_err;
  bit [2:0] m_stk[$];

  flag_ctrl #(
    .STACK_DEPTH(DEPTH),
    .IE_RST     (IE_RV)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .c_in     (c_in),
    .z_in     (z_in),
    .c_ld     (c_ld),
    .z_ld     (z_ld),
    .c_set    (c_set),
    .c_clr    (c_clr),
    .ie_set   (ie_set),
    .ie_clr   (ie_clr),
    .irq      (irq),
    .int_ack  (int_ack),
    .retie    (retie),
    .c_out    (c_out),
    .z_out    (z_out),
    .ie_out   (ie_out),
    .depth    (depth),
    .stk_full (stk_full),
`ifdef FLAG_STACK_ERR_EN
    .stk_err  (stk_err),
`endif
    .stk_empty(stk_empty)
  );

  always #5 clk = ~clk;

  function automatic void model_reset();
    m_c = 1'b0; m_z = 1'b0; m_ie = IE_RV;
    m_ack = 1'b0; m_isr = 1'b0; m_err = 1'b0;
    m_stk.delete();
  endfunction

  function automatic void model_step();
    bit [2:0] top = 3'b000;
    bit popped = 1'b0;
    bit enter = 1'b0;
    bit full = (m_stk.size() >= DEPTH);
    bit nc = m_c, nz = m_z, nie = m_ie, nisr = m_isr;
    if (m_ack) begin
      if (!full) m_stk.push_back({m_ie, m_z, m_c});
      nisr = 1'b1;
    end else if (m_isr && retie) begin
      if (m_stk.size() > 0) begin
        top = m_stk.pop_back();
        popped = 1'b1;
        nisr = (m_stk.size() != 0);
      end else begin
        nisr = 1'b0;
        m_err = 1'b1;
      end
    end else if (irq && m_ie && !retie) begin
      if (ERR_EN && full) m_err = 1'b1;
      else enter = 1'b1;
    end
    if (popped) begin
      {nie, nz, nc} = top;
    end else begin
      if (c_clr) nc = 1'b0; else if (c_set) nc = 1'b1; else if (c_ld) nc = c_in;
      if (z_ld) nz = z_in;
      if (m_ack) nie = 1'b0; else if (ie_clr) nie = 1'b0; else if (ie_set) nie = 1'b1;
    end
    m_c = nc; m_z = nz; m_ie = nie; m_isr = nisr; m_ack = enter;
  endfunction

  task automatic idle();
    c_in = 0; z_in = 0; c_ld = 0; z_ld = 0; c_set = 0; c_clr = 0;
    ie_set = 0; ie_clr = 0; irq = 0; retie = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic test_reset();
    idle();
    rst_n = 1'b0;
    model_reset();
    #3;
    total++; if (c_out !== 1'b0) begin bad++; $display("FAIL reset_c: got %b want 0", c_out); end
    total++; if (z_out !== 1'b0) begin bad++; $display("FAIL reset_z: got %b want 0", z_out); end
    total++; if (ie_out !== IE_RV) begin bad++; $display("FAIL reset_ie: got %b want %b", ie_out, IE_RV); end
    total++; if (int_ack !== 1'b0) begin bad++; $display("FAIL reset_ack: got %b want 0", int_ack); end
    total++; if (depth !== '0) begin bad++; $display("FAIL reset_depth: got %0d want 0", depth); end
    total++; if ({stk_full, stk_empty} !== 2'b01) begin bad++; $display("FAIL reset_stk: got %b want 01", {stk_full, stk_empty}); end
`ifdef FLAG_STACK_ERR_EN
    total++; if (stk_err !== 1'b0) begin bad++; $display("FAIL reset_err: got %b want 0", stk_err); end
`endif
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic test_c_priority();
    idle(); c_set = 1;
    tick();
    total++; if (c_out !== 1'b1) begin bad++; $display("FAIL c_set: got %b want 1", c_out); end
    c_clr = 1;
    tick();
    total++; if (c_out !== 1'b0) begin bad++; $display("FAIL c_clr_wins: got %b want 0", c_out); end
    idle();
  endtask

  task automatic test_load();
    idle(); c_in = 1; z_in = 1; c_ld = 1; z_ld = 1;
    tick();
    total++; if ({c_out, z_out} !== 2'b11) begin bad++; $display("FAIL load_cz: got %b want 11", {c_out, z_out}); end
    idle(); c_ld = 1; c_in = 0;
    tick();
    total++; if ({c_out, z_out} !== 2'b01) begin bad++; $display("FAIL load_c_only: got %b want 01", {c_out, z_out}); end
    idle();
  endtask

  task automatic test_isr();
    idle(); ie_set = 1; c_set = 1; z_ld = 1; z_in = 0;
    tick();
    total++; if ({ie_out, z_out, c_out} !== 3'b101) begin bad++; $display("FAIL isr_setup: got %b want 101", {ie_out, z_out, c_out}); end
    idle(); irq = 1;
    tick();
    total++; if (int_ack !== 1'b1) begin bad++; $display("FAIL isr_ack: got %b want 1", int_ack); end
    irq = 0;
    tick();
    total++; if ({int_ack, ie_out} !== 2'b00) begin bad++; $display("FAIL isr_ack_ie_after: got %b want 00", {int_ack, ie_out}); end
    total++; if (depth !== DW'(1)) begin bad++; $display("FAIL isr_depth: got %0d want 1", depth); end
    c_clr = 1; z_ld = 1; z_in = 1;
    tick();
    total++; if ({z_out, c_out} !== 2'b10) begin bad++; $display("FAIL isr_body: got %b want 10", {z_out, c_out}); end
    idle(); retie = 1;
    tick();
    total++; if ({ie_out, z_out, c_out} !== 3'b101) begin bad++; $display("FAIL isr_restore: got %b want 101", {ie_out, z_out, c_out}); end
    total++; if (depth !== '0) begin bad++; $display("FAIL isr_depth_end: got %0d want 0", depth); end
    idle();
  endtask

  task automatic test_retie_run();
    idle(); retie = 1;
    tick();
    total++; if ({ie_out, z_out, c_out} !== 3'b101) begin bad++; $display("FAIL retie_run_flags: got %b want 101", {ie_out, z_out, c_out}); end
    total++; if ({int_ack, depth} !== {1'b0, DW'(0)}) begin bad++; $display("FAIL retie_run_depth: got ack=%b depth=%0d want 0/0", int_ack, depth); end
`ifdef FLAG_STACK_ERR_EN
    total++; if (stk_err !== 1'b0) begin bad++; $display("FAIL retie_run_err: got %b want 0", stk_err); end
`endif
    irq = 1;
    tick();
    total++; if (int_ack !== 1'b0) begin bad++; $display("FAIL retie_blocks_irq: got %b want 0", int_ack); end
    idle();
  endtask

  task automatic test_nesting();
    idle(); irq = 1; ie_set = 1;
    tick();  // taken
    total++; if (int_ack !== 1'b1) begin bad++; $display("FAIL nest_ack1: got %b want 1", int_ack); end
    tick();  // pushed, IE cleared despite ie_set
    total++; if ({ie_out, depth} !== {1'b0, DW'(1)}) begin bad++; $display("FAIL nest_push1: got ie=%b depth=%0d want 0/1", ie_out, depth); end
    tick();  // ISR re-enables IE
    total++; if ({int_ack, ie_out} !== 2'b01) begin bad++; $display("FAIL nest_reenable: got %b want 01", {int_ack, ie_out}); end
    tick();
    total++; if (int_ack !== 1'b1) begin bad++; $display("FAIL nest_ack2: got %b want 1", int_ack); end
    tick();
    total++; if ({stk_full, depth} !== {1'b1, DW'(2)}) begin bad++; $display("FAIL nest_full: got full=%b depth=%0d want 1/2", stk_full, depth); end
    tick();  // IE back on, third request now visible
    tick();
    total++; if (int_ack !== !ERR_EN) begin bad++; $display("FAIL nest_ack3: got %b want %b", int_ack, !ERR_EN); end
`ifdef FLAG_STACK_ERR_EN
    total++; if (stk_err !== 1'b1) begin bad++; $display("FAIL nest_err: got %b want 1", stk_err); end
`endif
    idle();
    tick();
    total++; if ({int_ack, depth} !== {1'b0, DW'(2)}) begin bad++; $display("FAIL nest_saturate: got ack=%b depth=%0d want 0/2", int_ack, depth); end
    retie = 1;
    tick();
    total++; if ({ie_out, depth} !== {1'b1, DW'(1)}) begin bad++; $display("FAIL nest_pop1: got ie=%b depth=%0d want 1/1", ie_out, depth); end
    tick();
    total++; if ({ie_out, stk_empty} !== 2'b11) begin bad++; $display("FAIL nest_pop2: got ie=%b empty=%b want 1/1", ie_out, stk_empty); end
    idle();
  endtask

  task automatic test_reset_mid();
    idle(); irq = 1; c_set = 1;
    tick();
    idle();
    tick();
    total++; if ({c_out, depth} !== {1'b1, DW'(1)}) begin bad++; $display("FAIL mid_setup: got c=%b depth=%0d want 1/1", c_out, depth); end
    #2 rst_n = 1'b0;
    #1;  // still before the next rising edge
    total++; if ({c_out, z_out, ie_out, int_ack} !== {3'b000 | {IE_RV, 2'b00}, 1'b0}) begin bad++; $display("FAIL mid_reset_flags: got %b want %b", {c_out, z_out, ie_out, int_ack}, {2'b00, IE_RV, 1'b0}); end
    total++; if ({depth, stk_empty} !== {DW'(0), 1'b1}) begin bad++; $display("FAIL mid_reset_stk: got depth=%0d empty=%b want 0/1", depth, stk_empty); end
`ifdef FLAG_STACK_ERR_EN
    total++; if (stk_err !== 1'b0) begin bad++; $display("FAIL mid_reset_err: got %b want 0", stk_err); end
`endif
    model_reset();
    @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic test_random();
    for (int n = 0; n < 1500; n++) begin
      c_in   = 1'($urandom_range(0, 1));
      z_in   = 1'($urandom_range(0, 1));
      c_ld   = ($urandom_range(0, 99) < 30);
      z_ld   = ($urandom_range(0, 99) < 30);
      c_set  = ($urandom_range(0, 99) < 15);
      c_clr  = ($urandom_range(0, 99) < 15);
      ie_set = ($urandom_range(0, 99) < 35);
      ie_clr = ($urandom_range(0, 99) < 10);
      irq    = ($urandom_range(0, 99) < 45);
      retie  = ($urandom_range(0, 99) < 25);
      tick();
      total++;
      if ({c_out, z_out, ie_out, int_ack} !== {m_c, m_z, m_ie, m_ack}) begin
        bad++;
        $display("FAIL rand_flags cyc %0d: got czia=%b want %b", n, {c_out, z_out, ie_out, int_ack}, {m_c, m_z, m_ie, m_ack});
      end
      total++;
      if ({depth, stk_full, stk_empty} !== {DW'(m_stk.size()), m_stk.size() == DEPTH, m_stk.size() == 0}) begin
        bad++;
        $display("FAIL rand_stack cyc %0d: got depth=%0d f=%b e=%b want depth=%0d", n, depth, stk_full, stk_empty, m_stk.size());
      end
`ifdef FLAG_STACK_ERR_EN
      total++;
      if (stk_err !== m_err) begin bad++; $display("FAIL rand_err cyc %0d: got %b want %b", n, stk_err, m_err); end
`endif
    end
    idle();
  endtask

  initial begin
    test_reset();
    test_c_priority();
    test_load();
    test_isr();
    test_retie_run();
    test_nesting();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
